// File: rtl/float_pkg.sv
// float_pkg: shared states and IEEE-754 single-precision field constants for float_to_int.
package float_pkg;
  typedef enum logic [2:0] {GET_A, UNPACK, SPECIAL, CONVERT, PACK, PUT_Z} state_t;
  localparam int BIAS = 127;
  localparam logic [31:0] INT_MIN = 32'h8000_0000;
  localparam int SIGN_BIT = 31;
  localparam int EXP_HI = 30;
  localparam int EXP_LO = 23;
  localparam int FRAC_HI = 22;
  localparam int FRAC_LO = 0;
endpackage

// File: rtl/float_to_int.sv
// float_to_int: handshaked single-precision float to int32 conversion, truncating toward zero.
module float_to_int
  import float_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] input_a,
  input  logic        input_a_stb,
  output logic        input_a_ack,
  output logic [31:0] output_z,
  output logic        output_z_stb,
  input  logic        output_z_ack
);
  state_t state, state_n;
  logic [31:0] a, a_n, m, m_n, z_n;
  logic signed [9:0] e, e_n;
  logic sign, sign_n, stb_n, ack_n;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= GET_A;
      input_a_ack <= 1'b0;
      output_z_stb <= 1'b0;
      output_z <= '0;
      a <= '0;
      m <= '0;
      e <= '0;
      sign <= 1'b0;
    end else begin
      state <= state_n;
      input_a_ack <= ack_n;
      output_z_stb <= stb_n;
      output_z <= z_n;
      a <= a_n;
      m <= m_n;
      e <= e_n;
      sign <= sign_n;
    end
  end
  always_comb begin
    state_n = state;
    ack_n = input_a_ack;
    stb_n = output_z_stb;
    z_n = output_z;
    a_n = a;
    m_n = m;
    e_n = e;
    sign_n = sign;
    case (state)
      GET_A: begin
        ack_n = 1'b1;
        if (input_a_ack && input_a_stb) begin
          a_n = input_a;
          ack_n = 1'b0;
          state_n = UNPACK;
        end
      end
      UNPACK: begin
        sign_n = a[SIGN_BIT];
        e_n = {2'b00, a[EXP_HI:EXP_LO]} - 10'(BIAS);
        m_n = {1'b1, a[FRAC_HI:FRAC_LO], 8'b0};
        state_n = SPECIAL;
      end
      SPECIAL: begin
        // zero/denormal or |a| < 1 truncate to 0; anything too large saturates to INT_MIN
        if (a[EXP_HI:EXP_LO] == '0 || e[9]) begin
          z_n = '0;
          stb_n = 1'b1;
          state_n = PUT_Z;
        end else if (e > 10'sd30) begin
          z_n = INT_MIN;
          stb_n = 1'b1;
          state_n = PUT_Z;
        end else state_n = CONVERT;
      end
      CONVERT: begin
        if (e < 10'sd31) begin
          m_n = m >> 1;
          e_n = e + 10'sd1;
        end else state_n = PACK;
      end
      PACK: begin
        z_n = sign ? -m : m;
        stb_n = 1'b1;
        state_n = PUT_Z;
      end
      PUT_Z: begin
        if (output_z_ack) begin
          stb_n = 1'b0;
          ack_n = 1'b1;
          state_n = GET_A;
        end
      end
      default: state_n = GET_A;
    endcase
  end
endmodule

// File: tb/tb_float_to_int.sv
// tb_float_to_int: directed and random checks of float_to_int against an arithmetic reference model.
module tb_float_to_int;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [31:0] input_a = '0;
  logic input_a_stb = 1'b0;
  logic input_a_ack;
  logic [31:0] output_z;
  logic output_z_stb;
  logic output_z_ack = 1'b0;
  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  float_to_int dut (
    .clk(clk), .rst(rst),
    .input_a(input_a), .input_a_stb(input_a_stb), .input_a_ack(input_a_ack),
    .output_z(output_z), .output_z_stb(output_z_stb), .output_z_ack(output_z_ack)
  );

  // truncating conversion from the float's value: (1.frac) * 2^e, saturating out of range
  function automatic logic [31:0] model(input logic [31:0] f);
    int ex;
    longint mag;
    ex = int'(f[30:23]) - 127;
    if (f[30:23] == 8'd0 || ex < 0) return 32'd0;
    if (ex > 30) return 32'h8000_0000;
    mag = longint'({1'b1, f[22:0]});
    mag = (ex >= 23) ? (mag << (ex - 23)) : (mag >> (23 - ex));
    return f[31] ? 32'(-mag) : 32'(mag);
  endfunction

  function automatic int exp_lat(input logic [31:0] f);
    int ex;
    ex = int'(f[30:23]) - 127;
    return (f[30:23] == 8'd0 || ex < 0 || ex > 30) ? 3 : 36 - ex;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // one full transaction; called at a negedge
  task automatic run(input logic [31:0] f, input bit early, input bit junk, input int hold);
    int n;
    int lat;
    logic [31:0] z0;
    input_a = f;
    input_a_stb = 1'b1;
    n = 0;
    while (!input_a_ack && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk($sformatf("accept %h", f), 32'(input_a_ack), 32'd1);
    if (!input_a_ack) begin
      input_a_stb = 1'b0;
      return;
    end
    @(posedge clk);
    @(negedge clk);
    input_a_stb = junk;
    input_a = $urandom;
    output_z_ack = early;
    lat = 1;
    while (!output_z_stb && lat < 60) begin
      chk($sformatf("busy_ack %h", f), 32'(input_a_ack), 32'd0);
      @(negedge clk);
      lat++;
    end
    input_a_stb = 1'b0;
    chk($sformatf("stb %h", f), 32'(output_z_stb), 32'd1);
    chk($sformatf("value %h", f), output_z, model(f));
    chk($sformatf("latency %h", f), 32'(lat), 32'(exp_lat(f)));
    z0 = output_z;
    if (!early) begin
      for (int i = 0; i < hold; i++) begin
        @(negedge clk);
        chk("hold_z", output_z, z0);
        chk("hold_flags", 32'({output_z_stb, input_a_ack}), 32'd2);
      end
    end
    output_z_ack = 1'b1;
    @(posedge clk);
    @(negedge clk);
    output_z_ack = 1'b0;
    chk($sformatf("stb_fall %h", f), 32'(output_z_stb), 32'd0);
    chk($sformatf("ack_rise %h", f), 32'(input_a_ack), 32'd1);
  endtask

  initial begin
    logic [31:0] dir [12];
    logic [31:0] f;
    dir = '{32'h3F80_0000, 32'hC020_0000, 32'h47F1_2000, 32'h3F00_0000,
            32'h8000_0000, 32'h4F00_0000, 32'h7FC0_0000, 32'hCF00_0000,
            32'h4EFF_FFFF, 32'hCEFF_FFFF, 32'h0000_0001, 32'hBF7F_FFFF};
    repeat (3) @(negedge clk);
    chk("rst_ack", 32'(input_a_ack), 32'd0);
    chk("rst_stb", 32'(output_z_stb), 32'd0);
    chk("rst_z", output_z, 32'd0);
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("ack_after_rst", 32'(input_a_ack), 32'd1);

    foreach (dir[i]) run(dir[i], 1'b0, 1'b0, 0);

    run(32'h3F80_0000, 1'b0, 1'b0, 10);
    run(32'hC020_0000, 1'b1, 1'b0, 0);
    run(32'h4F00_0000, 1'b1, 1'b1, 0);
    run(32'h47F1_2000, 1'b0, 1'b1, 2);

    input_a = 32'h3F80_0000;
    input_a_stb = 1'b1;
    @(posedge clk);
    @(negedge clk);
    input_a_stb = 1'b0;
    repeat (10) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_stb", 32'(output_z_stb), 32'd0);
    chk("midrst_ack", 32'(input_a_ack), 32'd0);
    chk("midrst_z", output_z, 32'd0);
    @(posedge clk);
    @(negedge clk);
    chk("midrst_ack_rise", 32'(input_a_ack), 32'd1);
    repeat (30) @(negedge clk);
    chk("midrst_no_out", 32'(output_z_stb), 32'd0);
    run(32'h4040_0000, 1'b0, 1'b0, 0);

    for (int i = 0; i < 40; i++) begin
      f = $urandom;
      if (i % 4 != 3) f[30:23] = 8'($urandom_range(118, 162));
      run(f, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom_range(0, 3));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
